ssp_xfer_ctrl: RTL and testbench
================================

# ssp_xfer_ctrl

Transfer sequencer between the AHB-side register synchronizer and the SSP transmit path. When the synchronized descriptor becomes ready, the block fetches one command word and 1–4 data words from the local buffer memory. It hands each word to the SSP shifter over a valid/ready handshake and feeds each word to the CRC engine. It then optionally appends the CRC word and pulses `done`.

## Interface
- `DATA_WIDTH`, 16, word width of memory, SSP and CRC datapath
- `ADDR_WIDTH`, 6, buffer memory address width
- `HCLK`  in  1  system clock; all state changes on the rising edge
- `HRESET`  in  1  asynchronous, active-high reset
- `regs_ready`  in  1  descriptor-valid level from the synchronizer
- `dadr`  in  ADDR_WIDTH  first data word address
- `cadr`  in  ADDR_WIDTH  command word address
- `dlen`  in  2  data word count minus one (0→1 word … 3→4 words)
- `mem_rd`  out  1  memory read strobe; data returns the following cycle
- `mem_addr`  out  ADDR_WIDTH  memory read address
- `mem_rdata`  in  DATA_WIDTH  memory read data
- `tx_data`  out  DATA_WIDTH  word to SSP shifter
- `tx_valid`  out  1  `tx_data` valid
- `tx_ready`  in  1  SSP shifter accepts word
- `crc_clr`  out  1  clear CRC engine (one-cycle pulse)
- `crc_en`  out  1  CRC engine absorbs `crc_din` this cycle
- `crc_din`  out  DATA_WIDTH  word to CRC engine
- `crc_in`  in  DATA_WIDTH  current CRC value
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle completion pulse

## Operation
- **States:** IDLE, RD, WAIT, SEND, CRC, DONE.
- **Start:** `regs_ready` is registered every cycle. A rising edge (current high, previous low) seen in IDLE does all of the following:
  - latches `dadr`, `cadr` and `dlen`;
  - pulses `crc_clr`;
  - loads the word counter with `dlen`+2 (command word plus data words);
  - selects `cadr` as the first address;
  - moves to RD.
- **RD:** `mem_rd`=1 and `mem_addr` = current address, then → WAIT.
- **WAIT:** registers `mem_rdata` into `tx_data`, then → SEND.
- **SEND:**
  - `tx_valid`=1, and `tx_data` is held stable until `tx_ready`=1.
  - `crc_en`=1 in the first SEND cycle of each word only, with `crc_din`=`tx_data`.
  - On handshake the counter decrements. If the counter is nonzero, → RD; otherwise → CRC, or → DONE when CRC append is compiled out.
- **Address sequence:** `cadr`, then `dadr`, `dadr`+1, … The increment wraps modulo 2^ADDR_WIDTH (`dadr`=63, `dlen`=1 reads 63 then 0).
- **CRC:** `tx_data`=`crc_in` and `tx_valid`=1 until `tx_ready`=1, then → DONE. `crc_en`=0 in this state.
- **DONE:** `done`=1 for one cycle, then → IDLE.
- **`regs_ready` while busy:** a rising edge outside IDLE is ignored and not queued. A level held high through completion does not retrigger, because the edge detector keeps tracking while busy.
- **`tx_ready`:** may be high before `tx_valid`; the handshake completes in the first cycle both are high.
- **Input changes:** changes on `dadr`, `cadr` or `dlen` after the start edge have no effect on the current transfer.

## Timing
- **Reset values:** all outputs 0; state IDLE; edge register 0; counter and addresses 0.
- **Reset mid-transfer:** immediate return to IDLE with outputs 0, and no `done`.
- **Start latency:** with the first `regs_ready`-high cycle = N, `mem_rd` is high in N+1 and `tx_valid` first rises in N+3.
- **Per-word cost:** 3 cycles with `tx_ready` held high; each stall cycle adds one.
- **CRC word:** `crc_in` reflects the last data word one cycle after its `crc_en`. The CRC state is always at least one cycle after that `crc_en`.
- **`dlen`=0 with CRC and `tx_ready`=1:** data words in N+3 and N+6, CRC word in N+7, `done` in N+8, IDLE in N+9.
- **`busy`:** high N+1 through the DONE cycle inclusive.
- **Back-to-back transfers:** the earliest next start is a rising edge sampled in the first IDLE cycle.

## Configuration
- `SSP_CTRL_CRC_APPEND_EN`
  - **Defined:** CRC state present; the CRC word is sent after the last data word.
  - **Undefined:** CRC state removed; SEND goes directly to DONE after the last word. `crc_clr`, `crc_en` and `crc_din` are tied to 0, and `crc_in` is unused. In the `dlen`=0, `tx_ready`=1 case, `done` occurs in N+7.

## Test plan
- **Basic transfer, CRC on:** `cadr`=5, `dadr`=10, `dlen`=0, `tx_ready`=1, memory word = 0x1000+address. Required: `tx_data` sequence 0x1005, 0x100A, then `crc_in`; `done` at N+8; exactly two `crc_en` pulses.
- **Address wrap:** `dadr`=62, `dlen`=3. Required: `mem_addr` sequence `cadr`, 62, 63, 0, 1; five `tx_valid` handshakes.
- **Backpressure:** `tx_ready` low for 4 cycles on the second word. Required: `tx_data` stable while `tx_valid`=1; single `crc_en` per word; `done` delayed by exactly 4 cycles.
- **Retrigger while busy:** `regs_ready` held high for 30 cycles, plus a low/high toggle mid-transfer. Required: exactly one `done`; no new `mem_rd` after DONE.
- **Reset mid-transfer:** assert `HRESET` during SEND. Required: all outputs 0 immediately. After release, a new `regs_ready` edge starts a normal transfer.
- **Macro undefined:** `dlen`=1, `tx_ready`=1. Required: three words sent; `crc_en` never asserted; `done` at N+10.

Source files
------------

// File: rtl/ssp_xfer_ctrl_if.sv
// Bus bundle between ssp_xfer_ctrl (master side) and its environment:
// descriptor inputs, buffer-memory read port, SSP transmit handshake and CRC engine hookup.
interface ssp_xfer_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
);
  logic                  regs_ready;
  logic [ADDR_WIDTH-1:0] dadr;
  logic [ADDR_WIDTH-1:0] cadr;
  logic [1:0]            dlen;
  logic                  mem_rd;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  crc_clr;
  logic                  crc_en;
  logic [DATA_WIDTH-1:0] crc_din;
  logic [DATA_WIDTH-1:0] crc_in;
  logic                  busy;
  logic                  done;

  modport master (
    input  regs_ready, dadr, cadr, dlen, mem_rdata, tx_ready, crc_in,
    output mem_rd, mem_addr, tx_data, tx_valid, crc_clr, crc_en, crc_din, busy, done
  );

  modport slave (
    output regs_ready, dadr, cadr, dlen, mem_rdata, tx_ready, crc_in,
    input  mem_rd, mem_addr, tx_data, tx_valid, crc_clr, crc_en, crc_din, busy, done
  );
endinterface

// File: rtl/ssp_xfer_ctrl.sv
// Transfer sequencer: fetches a command word plus 1-4 data words, streams them to the SSP
// shifter and CRC engine. Define SSP_CTRL_CRC_APPEND_EN to append the CRC word after the data.
module ssp_xfer_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
) (
  input  logic           HCLK,
  input  logic           HRESET,
  ssp_xfer_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_SEND,
`ifdef SSP_CTRL_CRC_APPEND_EN
    S_CRC,
`endif
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic                  rr_q, rr_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] dadr_q, dadr_d;
  logic [1:0]            dlen_q, dlen_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  first_q, first_d;
  logic                  clr_q, clr_d;
  logic                  start;
  logic                  cmd_word;
  logic                  last_word;

  // The edge detector tracks regs_ready in every state, so a level held through DONE never retriggers.
  assign start     = bus.regs_ready && !rr_q;
  assign cmd_word  = (cnt_q == ({1'b0, dlen_q} + 3'd2));
  assign last_word = (cnt_q == 3'd1);

  always_comb begin
    state_d = state_q;
    rr_d    = bus.regs_ready;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    dadr_d  = dadr_q;
    dlen_d  = dlen_q;
    data_d  = data_q;
    first_d = first_q;
    clr_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dadr_d  = bus.dadr;
          dlen_d  = bus.dlen;
          cnt_d   = {1'b0, bus.dlen} + 3'd2;
          addr_d  = bus.cadr;
          clr_d   = 1'b1;
          state_d = S_RD;
        end
      end
      S_RD: state_d = S_WAIT;
      S_WAIT: begin
        data_d  = bus.mem_rdata;
        first_d = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        first_d = 1'b0;
        if (bus.tx_ready) begin
          cnt_d  = cnt_q - 3'd1;
          // After the command word the data block starts; data addresses wrap naturally.
          addr_d = cmd_word ? dadr_q : addr_q + ADDR_WIDTH'(1);
          if (!last_word) begin
            state_d = S_RD;
          end else begin
`ifdef SSP_CTRL_CRC_APPEND_EN
            state_d = S_CRC;
`else
            state_d = S_DONE;
`endif
          end
        end
      end
`ifdef SSP_CTRL_CRC_APPEND_EN
      S_CRC: if (bus.tx_ready) state_d = S_DONE;
`endif
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= S_IDLE;
      rr_q    <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      dadr_q  <= '0;
      dlen_q  <= '0;
      data_q  <= '0;
      first_q <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      dadr_q  <= dadr_d;
      dlen_q  <= dlen_d;
      data_q  <= data_d;
      first_q <= first_d;
      clr_q   <= clr_d;
    end
  end

  assign bus.mem_rd   = (state_q == S_RD);
  assign bus.mem_addr = addr_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);

`ifdef SSP_CTRL_CRC_APPEND_EN
  // crc_in is read live in the CRC state: it only settles one cycle after the last crc_en.
  assign bus.tx_valid = (state_q == S_SEND) || (state_q == S_CRC);
  assign bus.tx_data  = (state_q == S_CRC) ? bus.crc_in : data_q;
  assign bus.crc_clr  = clr_q;
  assign bus.crc_en   = (state_q == S_SEND) && first_q;
  assign bus.crc_din  = data_q;
`else
  assign bus.tx_valid = (state_q == S_SEND);
  assign bus.tx_data  = data_q;
  assign bus.crc_clr  = 1'b0;
  assign bus.crc_en   = 1'b0;
  assign bus.crc_din  = '0;

  logic unused_crc;
  assign unused_crc = ^{bus.crc_in, clr_q, first_q};
`endif
endmodule

// File: tb/tb_ssp_xfer_ctrl.sv
// Bench for ssp_xfer_ctrl: directed transfers against a queue-based transfer model,
// with a behavioural buffer memory and rotate-xor CRC engine.
`timescale 1ns/1ps
module tb_ssp_xfer_ctrl;
  localparam int DW = 16;
  localparam int AW = 6;
`ifdef SSP_CTRL_CRC_APPEND_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic HCLK = 1'b0;
  logic HRESET;

  ssp_xfer_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  ssp_xfer_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .HCLK  (HCLK),
    .HRESET(HRESET),
    .bus   (bus)
  );

  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [15:0] d);
    return {c[14:0], c[15]} ^ d;
  endfunction

  // Environment: memory returns 0x1000+address the cycle after mem_rd; CRC engine folds crc_din.
  logic [15:0] crc_q = '0;
  always @(posedge HCLK) begin
    if (bus.mem_rd) bus.mem_rdata <= 16'h1000 + 16'(bus.mem_addr);
    if (bus.crc_clr) crc_q <= '0;
    else if (bus.crc_en) crc_q <= crc_step(crc_q, bus.crc_din);
  end
  assign bus.crc_in = crc_q;

  // Transfer model state shared with the compare process
  logic        xfer_act = 1'b0;
  int          n_start = 0;
  int          exp_done_cyc = 0;
  int          done_cnt, crcen_cnt, first_valid, done_seen;
  int          done_total = 0;
  logic [5:0]  exp_addr[$];
  logic [15:0] exp_word[$];
  logic [15:0] exp_crcdin[$];
  logic [5:0]  addr_log[$];
  logic [15:0] word_log[$];
  logic        prev_valid = 1'b0, prev_ready = 1'b0;
  logic [15:0] prev_data = '0;

  always @(negedge HCLK) begin
    if (bus.done) done_total++;
    if (xfer_act) begin
      chk("busy", bus.busy, (cyc >= n_start + 1) && (cyc <= exp_done_cyc));
      chk("crc_clr", bus.crc_clr, CRC_ON && (cyc == n_start + 1));
      if (bus.mem_rd) begin
        addr_log.push_back(bus.mem_addr);
        if (exp_addr.size() == 0) chk("extra_mem_rd", exp_addr.size(), 1);
        else chk("mem_addr", bus.mem_addr, exp_addr.pop_front());
      end
      if (bus.crc_en) begin
        crcen_cnt++;
        if (exp_crcdin.size() == 0) chk("extra_crc_en", exp_crcdin.size(), 1);
        else chk("crc_din", bus.crc_din, exp_crcdin.pop_front());
      end
      if (bus.tx_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (prev_valid && !prev_ready) chk("tx_data_hold", bus.tx_data, prev_data);
        if (bus.tx_ready) begin
          word_log.push_back(bus.tx_data);
          if (exp_word.size() == 0) chk("extra_handshake", exp_word.size(), 1);
          else chk("tx_data", bus.tx_data, exp_word.pop_front());
        end
      end
      if (bus.done) begin
        done_cnt++;
        done_seen = cyc;
        chk("done_cycle", cyc, exp_done_cyc);
      end
    end
    prev_valid = bus.tx_valid;
    prev_ready = bus.tx_ready;
    prev_data  = bus.tx_data;
  end

  // stall: tx_ready low for cycles N+6..N+6+stall-1 (second word's SEND);
  // hold: regs_ready high for N..N+hold-1 with a low blip at N+4.
  task automatic run_xfer(input logic [5:0] c, input logic [5:0] d, input logic [1:0] l,
                          input int stall, input int hold);
    int w;
    int rel;
    int span;
    logic [15:0] cr;
    logic [5:0]  a;
    w  = int'(l) + 2;
    cr = '0;
    exp_addr.delete(); exp_word.delete(); exp_crcdin.delete();
    addr_log.delete(); word_log.delete();
    for (int i = 0; i < w; i++) begin
      a = (i == 0) ? c : 6'(d + 6'(i - 1));
      exp_addr.push_back(a);
      exp_word.push_back(16'h1000 + 16'(a));
      exp_crcdin.push_back(16'h1000 + 16'(a));
      cr = crc_step(cr, 16'h1000 + 16'(a));
    end
    if (CRC_ON) exp_word.push_back(cr);
    else exp_crcdin.delete();
    rel  = 3 * w + stall + (CRC_ON ? 2 : 1);
    span = ((rel > hold) ? rel : hold) + 6;
    @(posedge HCLK); #1;
    bus.cadr = c; bus.dadr = d; bus.dlen = l;
    bus.regs_ready = 1'b1;
    bus.tx_ready = 1'b1;
    n_start = cyc; exp_done_cyc = cyc + rel;
    done_cnt = 0; crcen_cnt = 0; first_valid = -1; done_seen = -1;
    xfer_act = 1'b1;
    for (int k = 1; k <= span; k++) begin
      @(posedge HCLK); #1;
      bus.cadr = ~c; bus.dadr = ~d; bus.dlen = ~l;
      bus.regs_ready = (k < hold) && (k != 4);
      bus.tx_ready = !((stall > 0) && (k >= 6) && (k < 6 + stall));
    end
    @(negedge HCLK); #1;
    xfer_act = 1'b0;
    chk("done_count", done_cnt, 1);
    chk("crc_en_count", crcen_cnt, CRC_ON ? w : 0);
    chk("first_tx_valid", first_valid, n_start + 3);
    chk("words_left", exp_word.size(), 0);
    chk("reads_left", exp_addr.size(), 0);
  endtask

  task automatic check_zero(input string p);
    chk({p, "_mem_rd"},   bus.mem_rd, 0);
    chk({p, "_mem_addr"}, bus.mem_addr, 0);
    chk({p, "_tx_data"},  bus.tx_data, 0);
    chk({p, "_tx_valid"}, bus.tx_valid, 0);
    chk({p, "_crc_clr"},  bus.crc_clr, 0);
    chk({p, "_crc_en"},   bus.crc_en, 0);
    chk({p, "_crc_din"},  bus.crc_din, 0);
    chk({p, "_busy"},     bus.busy, 0);
    chk({p, "_done"},     bus.done, 0);
  endtask

  logic [5:0] wrap_exp [5];
  int n_rst;
  int done_snap;

  initial begin
    HRESET = 1'b1;
    bus.regs_ready = 1'b0; bus.tx_ready = 1'b0;
    bus.cadr = '0; bus.dadr = '0; bus.dlen = '0;
    bus.mem_rdata = '0;
    wrap_exp = '{6'd7, 6'd62, 6'd63, 6'd0, 6'd1};
    repeat (2) @(negedge HCLK);
    check_zero("reset");
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    repeat (2) @(posedge HCLK);
    #1 check_zero("idle");

    // Basic transfer: cadr=5, dadr=10, one data word
    run_xfer(6'd5, 6'd10, 2'd0, 0, 0);
    chk("pin_basic_done_rel", done_seen - n_start, CRC_ON ? 8 : 7);
    chk("pin_basic_nwords", word_log.size(), CRC_ON ? 3 : 2);
    if (word_log.size() >= 2) begin
      chk("pin_basic_w0", word_log[0], 16'h1005);
      chk("pin_basic_w1", word_log[1], 16'h100A);
    end
`ifdef SSP_CTRL_CRC_APPEND_EN
    if (word_log.size() >= 3) chk("pin_basic_crc", word_log[2], 16'h3000);
`endif

    // Address wrap: dadr=62, four data words
    run_xfer(6'd7, 6'd62, 2'd3, 0, 0);
    chk("pin_wrap_nreads", addr_log.size(), 5);
    if (addr_log.size() == 5)
      for (int i = 0; i < 5; i++) chk("pin_wrap_addr", addr_log[i], wrap_exp[i]);
    chk("pin_wrap_handshakes", word_log.size(), CRC_ON ? 6 : 5);

    // Backpressure: second word stalled 4 cycles
    run_xfer(6'd5, 6'd10, 2'd0, 4, 0);
    chk("pin_bp_done_rel", done_seen - n_start, CRC_ON ? 12 : 11);

    // Retrigger while busy: level held 30 cycles with a blip mid-transfer
    run_xfer(6'd3, 6'd20, 2'd1, 0, 30);

    // Reset mid-transfer while stalled in SEND
    @(posedge HCLK); #1;
    bus.cadr = 6'd2; bus.dadr = 6'd30; bus.dlen = 2'd3;
    bus.regs_ready = 1'b1; bus.tx_ready = 1'b0;
    n_rst = cyc;
    @(posedge HCLK); #1;
    bus.regs_ready = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    chk("pre_rst_cycle", cyc - n_rst, 4);
    chk("pre_rst_tx_valid", bus.tx_valid, 1);
    done_snap = done_total;
    HRESET = 1'b1;
    #1 check_zero("rst_mid");
    repeat (2) @(posedge HCLK);
    #1 HRESET = 1'b0;
    repeat (3) @(posedge HCLK);
    #1 chk("no_done_after_rst", done_total - done_snap, 0);
    run_xfer(6'd4, 6'd12, 2'd0, 0, 0);

    // dlen=1, tx_ready held high: three words
    run_xfer(6'd1, 6'd40, 2'd1, 0, 0);
    chk("pin_dlen1_done_rel", done_seen - n_start, CRC_ON ? 11 : 10);
    chk("pin_dlen1_nwords", word_log.size(), CRC_ON ? 4 : 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
